// File: rtl/prio_intp_pkg.sv
// Shared types and register-map constants for the priority interrupt controller.
package prio_intp_pkg;

  // Grant state machine: either no grant outstanding, or waiting for acknowledge.
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } state_t;

  // Priority registers occupy offsets PRIO_REG_BASE .. PRIO_REG_BASE+NUM_SRC-1.
  localparam int unsigned PRIO_REG_BASE = 0;

  // The read-only grant register sits directly above the priority block.
  function automatic int unsigned grant_reg_offset(input int unsigned num_src);
    return PRIO_REG_BASE + num_src;
  endfunction

endpackage

// File: rtl/prio_intp_arb.sv
// Combinational arbiter: picks the highest-priority eligible source,
// resolving equal priorities in favour of the lowest index.
module prio_intp_arb
  import prio_intp_pkg::*;
#(
  parameter  int NUM_SRC = 16,
  parameter  int PRIO_W  = 4,
  localparam int IDX_W   = $clog2(NUM_SRC)
) (
  input  logic [NUM_SRC-1:0]             eligible,
  input  logic [NUM_SRC-1:0][PRIO_W-1:0] prio,
  output logic [IDX_W-1:0]               win_idx,
  output logic [PRIO_W-1:0]              win_prio,
  output logic                           any_valid
);

  // Ascending scan with strict '>' keeps the first (lowest-index) of equal priorities.
  always_comb begin
    win_idx  = '0;
    win_prio = '0;
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      if (eligible[i] && (prio[i] > win_prio)) begin
        win_prio = prio[i];
        win_idx  = IDX_W'(i);
      end
    end
    any_valid = (win_prio != '0);
  end

endmodule

// File: rtl/prio_intp_ctrl.sv
// Priority interrupt controller with APB-programmable per-source priorities,
// edge or level capture, and a single outstanding grant with acknowledge.
module prio_intp_ctrl
  import prio_intp_pkg::*;
#(
  parameter  int NUM_SRC   = 16,
  parameter  int PRIO_W    = 4,
  parameter  int EDGE_MODE = 1,
  parameter  int PREEMPT   = 0,
  localparam int IDX_W     = $clog2(NUM_SRC),
  localparam int ADDR_W    = IDX_W + 1
) (
  input  logic               pclk_i,
  input  logic               prst_i,
  input  logic               psel_i,
  input  logic               penable_i,
  input  logic               pwrite_i,
  input  logic [ADDR_W-1:0]  paddr_i,
  input  logic [PRIO_W-1:0]  pwdata_i,
  output logic [PRIO_W-1:0]  prdata_o,
  output logic               pready_o,
  output logic               perror_o,
  input  logic [NUM_SRC-1:0] intp_active_i,
  output logic               intp_valid_o,
  output logic [IDX_W-1:0]   intp_to_service_o,
  input  logic               intp_serviced_i
);

  state_t                         state_q;
  logic [NUM_SRC-1:0][PRIO_W-1:0] prio_q;
  logic [NUM_SRC-1:0]             pend_q;
  logic [NUM_SRC-1:0]             act_q;
  logic [NUM_SRC-1:0]             set_vec;
  logic [NUM_SRC-1:0]             clr_vec;
  logic [NUM_SRC-1:0]             elig;
  logic [IDX_W-1:0]               win_idx;
  logic [PRIO_W-1:0]              win_prio;
  logic                           any_valid;
  logic [PRIO_W-1:0]              granted_prio;
  logic                           access;
  logic                           hit_prio;
  logic                           hit_grant;
  logic                           acc_err;
  logic [PRIO_W-1:0]              grant_rd;
  logic [PRIO_W-1:0]              rd_val;

  // An access is taken once, in the first psel&penable cycle; pready then
  // masks the still-high controls during the response cycle.
  always_comb begin
    access = psel_i & penable_i & ~pready_o;
  end

  // Register decode and read mux; the grant register reads zero while idle.
  always_comb begin
    rd_val   = '0;
    hit_prio = 1'b0;
    grant_rd = (state_q == ST_WAIT) ? PRIO_W'(intp_to_service_o) : '0;
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      if (paddr_i == ADDR_W'(PRIO_REG_BASE + i)) begin
        hit_prio = 1'b1;
        rd_val   = prio_q[i];
      end
    end
    hit_grant = (paddr_i == ADDR_W'(grant_reg_offset(NUM_SRC)));
    if (hit_grant) begin
      rd_val = grant_rd;
    end
    acc_err = ~hit_prio & ~(hit_grant & ~pwrite_i);
  end

  // APB response and priority register writes; errored accesses change nothing.
  always_ff @(posedge pclk_i) begin
    if (prst_i) begin
      pready_o <= 1'b0;
      perror_o <= 1'b0;
      prdata_o <= '0;
      prio_q   <= '0;
    end else begin
      pready_o <= access;
      perror_o <= access & acc_err;
      prdata_o <= '0;
      if (access && !acc_err) begin
        if (pwrite_i) begin
          for (int unsigned i = 0; i < NUM_SRC; i++) begin
            if (paddr_i == ADDR_W'(PRIO_REG_BASE + i)) begin
              prio_q[i] <= pwdata_i;
            end
          end
        end else begin
          prdata_o <= rd_val;
        end
      end
    end
  end

  // Capture request, acknowledge-clear vector, eligibility and the granted source's priority.
  always_comb begin
    set_vec      = (EDGE_MODE != 0) ? (intp_active_i & ~act_q) : intp_active_i;
    clr_vec      = '0;
    elig         = '0;
    granted_prio = '0;
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      elig[i] = pend_q[i] & (prio_q[i] != '0);
      if (intp_to_service_o == IDX_W'(i)) begin
        granted_prio = prio_q[i];
        clr_vec[i]   = (state_q == ST_WAIT) & intp_serviced_i;
      end
    end
  end

  // Pending flags and edge history; a new capture overrides a same-cycle clear.
  always_ff @(posedge pclk_i) begin
    if (prst_i) begin
      act_q  <= '0;
      pend_q <= '0;
    end else begin
      act_q  <= intp_active_i;
      pend_q <= (pend_q & ~clr_vec) | set_vec;
    end
  end

  prio_intp_arb #(
    .NUM_SRC (NUM_SRC),
    .PRIO_W  (PRIO_W)
  ) u_arb (
    .eligible  (elig),
    .prio      (prio_q),
    .win_idx   (win_idx),
    .win_prio  (win_prio),
    .any_valid (any_valid)
  );

  // Grant FSM: issue the arbiter winner, hold it until acknowledged,
  // optionally letting a strictly higher priority replace it.
  always_ff @(posedge pclk_i) begin
    if (prst_i) begin
      state_q           <= ST_IDLE;
      intp_valid_o      <= 1'b0;
      intp_to_service_o <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (any_valid) begin
            intp_to_service_o <= win_idx;
            intp_valid_o      <= 1'b1;
            state_q           <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (intp_serviced_i) begin
            intp_valid_o      <= 1'b0;
            intp_to_service_o <= '0;
            state_q           <= ST_IDLE;
          end else if ((PREEMPT != 0) && any_valid && (win_prio > granted_prio)) begin
            intp_to_service_o <= win_idx;
          end
        end
        default: begin
          intp_valid_o      <= 1'b0;
          intp_to_service_o <= '0;
          state_q           <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_prio_intp_ctrl.sv
// Directed bench for prio_intp_ctrl: a non-preempting and a preempting
// instance share all inputs so their grant behaviour can be compared.
module tb_prio_intp_ctrl;

  localparam int NUM_SRC = 16;
  localparam int PRIO_W  = 4;
  localparam int IDX_W   = 4;
  localparam int ADDR_W  = 5;

  logic               clk = 1'b0;
  logic               rst;
  logic               psel;
  logic               penable;
  logic               pwrite;
  logic [ADDR_W-1:0]  paddr;
  logic [PRIO_W-1:0]  pwdata;
  logic [NUM_SRC-1:0] intp_active;
  logic               serviced;

  logic [PRIO_W-1:0]  prdata0, prdata1;
  logic               pready0, pready1;
  logic               perror0, perror1;
  logic               valid0, valid1;
  logic [IDX_W-1:0]   idx0, idx1;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  prio_intp_ctrl #(
    .NUM_SRC   (NUM_SRC),
    .PRIO_W    (PRIO_W),
    .EDGE_MODE (1),
    .PREEMPT   (0)
  ) dut0 (
    .pclk_i            (clk),
    .prst_i            (rst),
    .psel_i            (psel),
    .penable_i         (penable),
    .pwrite_i          (pwrite),
    .paddr_i           (paddr),
    .pwdata_i          (pwdata),
    .prdata_o          (prdata0),
    .pready_o          (pready0),
    .perror_o          (perror0),
    .intp_active_i     (intp_active),
    .intp_valid_o      (valid0),
    .intp_to_service_o (idx0),
    .intp_serviced_i   (serviced)
  );

  prio_intp_ctrl #(
    .NUM_SRC   (NUM_SRC),
    .PRIO_W    (PRIO_W),
    .EDGE_MODE (1),
    .PREEMPT   (1)
  ) dut1 (
    .pclk_i            (clk),
    .prst_i            (rst),
    .psel_i            (psel),
    .penable_i         (penable),
    .pwrite_i          (pwrite),
    .paddr_i           (paddr),
    .pwdata_i          (pwdata),
    .prdata_o          (prdata1),
    .pready_o          (pready1),
    .perror_o          (perror1),
    .intp_active_i     (intp_active),
    .intp_valid_o      (valid1),
    .intp_to_service_o (idx1),
    .intp_serviced_i   (serviced)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apb_xfer(input logic wr, input logic [ADDR_W-1:0] a,
                          input logic [PRIO_W-1:0] d,
                          output logic [PRIO_W-1:0] rd, output logic err);
    int n;
    paddr   = a;
    pwrite  = wr;
    pwdata  = d;
    psel    = 1'b1;
    penable = 1'b0;
    tick();
    check("apb_no_ready_in_setup", pready0, 0);
    penable = 1'b1;
    tick();
    n = 0;
    while (!pready0 && n < 4) begin
      tick();
      n++;
    end
    check("apb_ready", pready0, 1);
    check("apb_wait_states", n, 0);
    rd  = prdata0;
    err = perror0;
    tick();
    psel    = 1'b0;
    penable = 1'b0;
    pwrite  = 1'b0;
    check("apb_ready_one_cycle", pready0, 0);
  endtask

  task automatic wr_reg(input logic [ADDR_W-1:0] a, input logic [PRIO_W-1:0] d);
    logic [PRIO_W-1:0] rd;
    logic              err;
    apb_xfer(1'b1, a, d, rd, err);
    check("wr_err", err, 0);
  endtask

  task automatic pulse(input logic [NUM_SRC-1:0] m);
    intp_active = m;
    tick();
    intp_active = '0;
  endtask

  task automatic ack();
    serviced = 1'b1;
    tick();
    serviced = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [PRIO_W-1:0] v;
    logic              e;

    rst         = 1'b1;
    psel        = 1'b0;
    penable     = 1'b0;
    pwrite      = 1'b0;
    paddr       = '0;
    pwdata      = '0;
    intp_active = '0;
    serviced    = 1'b0;
    repeat (3) tick();

    check("rst_valid", valid0, 0);
    check("rst_idx", idx0, 0);
    check("rst_pready", pready0, 0);
    check("rst_perror", perror0, 0);
    check("rst_prdata", prdata0, 0);
    check("rst_valid_pre", valid1, 0);
    rst = 1'b0;
    tick();

    // Two sources pulsed together: higher priority first, other after ack.
    wr_reg(5'd2, 4'd3);
    wr_reg(5'd5, 4'd7);
    pulse(16'h0024);
    check("r31_no_valid_yet", valid0, 0);
    tick();
    check("r31_valid", valid0, 1);
    check("r31_idx", idx0, 5);
    apb_xfer(1'b0, 5'd16, 4'd0, v, e);
    check("r31_grant_reg_err", e, 0);
    check("r31_grant_reg", v, 5);
    ack();
    check("r31_ack_clears", valid0, 0);
    tick();
    check("r31_second_valid", valid0, 1);
    check("r31_second_idx", idx0, 2);
    ack();
    check("r31_second_ack", valid0, 0);
    tick();
    check("r31_nothing_left", valid0, 0);
    apb_xfer(1'b0, 5'd16, 4'd0, v, e);
    check("r26_grant_reg_idle", v, 0);

    // Equal priorities, held high together: lowest index first, no re-arm while held.
    wr_reg(5'd4, 4'd6);
    wr_reg(5'd9, 4'd6);
    intp_active = 16'h0210;
    tick();
    tick();
    check("r32_valid", valid0, 1);
    check("r32_idx_first", idx0, 4);
    ack();
    check("r32_ack", valid0, 0);
    tick();
    check("r32_valid2", valid0, 1);
    check("r32_idx_second", idx0, 9);
    ack();
    intp_active = '0;
    tick();
    check("r32_no_rearm", valid0, 0);

    // Disabled source keeps its pending flag until enabled.
    pulse(16'h0002);
    tick();
    tick();
    check("r33_disabled_no_valid", valid0, 0);
    wr_reg(5'd1, 4'd1);
    check("r33_enabled_valid", valid0, 1);
    check("r33_enabled_idx", idx0, 1);
    ack();
    check("r33_ack", valid0, 0);

    // Higher-priority arrival during a grant: preempting instance switches.
    wr_reg(5'd3, 4'd2);
    wr_reg(5'd8, 4'd9);
    pulse(16'h0008);
    tick();
    check("r34_np_idx3", idx0, 3);
    check("r34_p_idx3", idx1, 3);
    check("r34_p_valid", valid1, 1);
    pulse(16'h0100);
    tick();
    check("r34_np_valid_held", valid0, 1);
    check("r34_np_stays3", idx0, 3);
    check("r34_p_valid_held", valid1, 1);
    check("r34_p_now8", idx1, 8);
    ack();
    check("r34_np_ack", valid0, 0);
    check("r34_p_ack", valid1, 0);
    tick();
    check("r34_np_next8", idx0, 8);
    check("r34_p_next3", idx1, 3);
    check("r34_np_next_valid", valid0, 1);
    ack();
    tick();
    check("r34_np_done", valid0, 0);
    check("r34_p_done", valid1, 0);

    // Error responses leave the grant and registers untouched.
    pulse(16'h0004);
    tick();
    check("r35_grant_valid", valid0, 1);
    check("r35_grant_idx", idx0, 2);
    apb_xfer(1'b1, 5'd16, 4'd5, v, e);
    check("r35_wr_grant_err", e, 1);
    check("r35_grant_kept_valid", valid0, 1);
    check("r35_grant_kept_idx", idx0, 2);
    apb_xfer(1'b0, 5'd5, 4'd0, v, e);
    check("r35_rd_prio5_err", e, 0);
    check("r35_rd_prio5", v, 7);
    apb_xfer(1'b0, 5'd17, 4'd0, v, e);
    check("r35_rd_unmapped_err", e, 1);
    check("r35_rd_unmapped_data", v, 0);
    apb_xfer(1'b1, 5'd31, 4'd15, v, e);
    check("r35_wr_unmapped_err", e, 1);
    ack();
    tick();
    check("r35_after_ack", valid0, 0);

    // New edge coincident with ack re-grants after one idle cycle; reset aborts grant.
    pulse(16'h0004);
    tick();
    check("r36_grant_valid", valid0, 1);
    intp_active = 16'h0004;
    serviced    = 1'b1;
    tick();
    intp_active = '0;
    serviced    = 1'b0;
    check("r36_idle_gap", valid0, 0);
    tick();
    check("r36_regrant_valid", valid0, 1);
    check("r36_regrant_idx", idx0, 2);
    rst = 1'b1;
    tick();
    check("r36_rst_valid", valid0, 0);
    check("r36_rst_idx", idx0, 0);
    check("r36_rst_valid_pre", valid1, 0);
    check("r36_rst_pready", pready0, 0);
    rst = 1'b0;
    tick();
    apb_xfer(1'b0, 5'd5, 4'd0, v, e);
    check("r27_prio_cleared", v, 0);
    check("r27_no_grant", valid0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
